// File: rtl/rv_rr_arbiter_if.sv
// Ready/valid bundle between NUM_REQ requesters, the round-robin arbiter and its sink.
// out_id is present only when RV_ARB_ID_EN is defined.
interface rv_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        in_valid;
  logic [NUM_REQ-1:0]        in_last;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        in_ready;
  logic                      out_valid;
  logic                      out_last;
  logic [DATA_W-1:0]         data_out;
  logic                      out_ready;
`ifdef RV_ARB_ID_EN
  logic [$clog2(NUM_REQ)-1:0] out_id;
`endif

  modport master (
    output in_valid, in_last, data_in, out_ready,
    input  in_ready, out_valid, out_last, data_out
`ifdef RV_ARB_ID_EN
    , input out_id
`endif
  );

  modport slave (
    input  in_valid, in_last, data_in, out_ready,
    output in_ready, out_valid, out_last, data_out
`ifdef RV_ARB_ID_EN
    , output out_id
`endif
  );
endinterface

// File: rtl/rv_rr_arbiter.sv
// Packet-aware round-robin arbiter feeding a one-entry output register slice.
// Define RV_ARB_ID_EN to add the registered source index out_id.
//
// state | meaning
// IDLE  | between packets; grant goes to first valid requester from rr_ptr
// LOCK  | mid-packet; grant pinned to lock_id until its last beat is accepted
module rv_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ID_W    = 2
) (
  input  logic            clk,
  input  logic            reset,
  rv_rr_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   lock_id;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_vld;
  logic              slot_free;
  logic              accept;
  logic [DATA_W-1:0] beat;
  logic              beat_last;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  // Descending scan so the requester closest to rr_ptr is the last (winning) write.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    if (state == LOCK) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (bus.in_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
          gnt_vld = 1'b1;
          gnt_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        end
      end
    end
  end

  assign slot_free = ~bus.out_valid | bus.out_ready;

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.in_ready[i] = gnt_vld && (gnt_id == ID_W'(i)) && slot_free && !reset;
    end
  end

  assign accept    = |(bus.in_valid & bus.in_ready);
  assign beat      = bus.data_in[int'(gnt_id)*DATA_W +: DATA_W];
  assign beat_last = bus.in_last[gnt_id];

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.data_out  <= '0;
`ifdef RV_ARB_ID_EN
      bus.out_id    <= '0;
`endif
      rr_ptr        <= '0;
      lock_id       <= '0;
      state         <= IDLE;
    end else begin
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_last  <= beat_last;
        bus.data_out  <= beat;
`ifdef RV_ARB_ID_EN
        bus.out_id    <= gnt_id;
`endif
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      // rr_ptr moves only when a packet completes.
      if (accept) begin
        case (state)
          IDLE: begin
            if (beat_last) begin
              rr_ptr <= next_id(gnt_id);
            end else begin
              state   <= LOCK;
              lock_id <= gnt_id;
            end
          end
          LOCK: begin
            if (beat_last) begin
              state  <= IDLE;
              rr_ptr <= next_id(lock_id);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Directed self-checking bench for rv_rr_arbiter (NUM_REQ=4, DATA_W=16).
module tb_rv_rr_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  rv_rr_arbiter_if #(.NUM_REQ(4), .DATA_W(16)) bus ();

  rv_rr_arbiter #(.NUM_REQ(4), .DATA_W(16), .ID_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [15:0] val);
    bus.data_in[idx*16 +: 16] = val;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 4'b1111;
    bus.in_last = 4'b0000;
    bus.data_in = '0;
    bus.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready_pre got=%b exp=0000", bus.in_ready); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (bus.in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0000", bus.in_ready); end
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      n_cmp++;
      if (bus.data_out !== 16'h0000) begin n_err++; $display("FAIL reset_data_out got=%h exp=0000", bus.data_out); end
      n_cmp++;
      if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
    end
    reset = 1'b0;
  endtask

  task automatic test_rotate();
    logic [3:0] exp_rdy;
    for (int i = 0; i < 4; i++) set_data(i, 16'h00A0 + 16'(i));
    bus.in_last = 4'b1111;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_rdy = 4'(1 << (k % 4));
      #1;
      n_cmp++;
      if (bus.in_ready !== exp_rdy) begin n_err++; $display("FAIL rotate_in_ready k=%0d got=%b exp=%b", k, bus.in_ready, exp_rdy); end
      tick();
      n_cmp++;
      if (bus.data_out !== 16'h00A0 + 16'(k % 4)) begin n_err++; $display("FAIL rotate_data k=%0d got=%h exp=%h", k, bus.data_out, 16'h00A0 + 16'(k % 4)); end
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1) begin n_err++; $display("FAIL rotate_vl k=%0d got=%b%b exp=11", k, bus.out_valid, bus.out_last); end
`ifdef RV_ARB_ID_EN
      n_cmp++;
      if (bus.out_id !== 2'(k % 4)) begin n_err++; $display("FAIL rotate_id k=%0d got=%0d exp=%0d", k, bus.out_id, k % 4); end
`endif
    end
    bus.in_valid = 4'b0000;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rotate_drain got=%b exp=0", bus.out_valid); end
  endtask

  // rr_ptr is 1 here: req1 sends a 3-beat packet while req2 waits.
  task automatic test_packet();
    bus.in_valid = 4'b0110;
    bus.in_last = 4'b0100;
    set_data(1, 16'h1001);
    set_data(2, 16'h2001);
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0010) begin n_err++; $display("FAIL pkt_rdy1 got=%b exp=0010", bus.in_ready); end
    tick();
    n_cmp++;
    if (bus.data_out !== 16'h1001 || bus.out_last !== 1'b0) begin n_err++; $display("FAIL pkt_beat1 got=%h/%b exp=1001/0", bus.data_out, bus.out_last); end
    set_data(1, 16'h1002);
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0010) begin n_err++; $display("FAIL pkt_rdy2 got=%b exp=0010", bus.in_ready); end
    tick();
    n_cmp++;
    if (bus.data_out !== 16'h1002 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL pkt_beat2 got=%h/%b exp=1002/1", bus.data_out, bus.out_valid); end
`ifdef RV_ARB_ID_EN
    n_cmp++;
    if (bus.out_id !== 2'd1) begin n_err++; $display("FAIL pkt_id got=%0d exp=1", bus.out_id); end
`endif
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    set_data(1, 16'h1003);
    bus.in_last = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (bus.in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_in_ready c=%0d got=%b exp=0000", c, bus.in_ready); end
      tick();
      n_cmp++;
      if (bus.data_out !== 16'h1002 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold c=%0d got=%h/%b exp=1002/1", c, bus.data_out, bus.out_valid); end
    end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_rdy got=%b exp=0010", bus.in_ready); end
    tick();
    n_cmp++;
    if (bus.data_out !== 16'h1003 || bus.out_valid !== 1'b1 || bus.out_last !== 1'b1) begin n_err++; $display("FAIL bp_nobubble got=%h/%b/%b exp=1003/1/1", bus.data_out, bus.out_valid, bus.out_last); end
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0100) begin n_err++; $display("FAIL pkt_next_req2 got=%b exp=0100", bus.in_ready); end
    tick();
    n_cmp++;
    if (bus.data_out !== 16'h2001) begin n_err++; $display("FAIL pkt_req2_data got=%h exp=2001", bus.data_out); end
`ifdef RV_ARB_ID_EN
    n_cmp++;
    if (bus.out_id !== 2'd2) begin n_err++; $display("FAIL pkt_req2_id got=%0d exp=2", bus.out_id); end
`endif
    bus.in_valid = 4'b0000;
    tick();
  endtask

  // rr_ptr is 3 here.
  task automatic test_wrap();
    bus.in_last = 4'b1111;
    bus.in_valid = 4'b1000;
    set_data(3, 16'h0003);
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_rdy3 got=%b exp=1000", bus.in_ready); end
    tick();
    n_cmp++;
    if (bus.data_out !== 16'h0003) begin n_err++; $display("FAIL wrap_data3 got=%h exp=0003", bus.data_out); end
    bus.in_valid = 4'b1001;
    set_data(0, 16'h00B0);
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_req0_wins got=%b exp=0001", bus.in_ready); end
    tick();
    n_cmp++;
    if (bus.data_out !== 16'h00B0) begin n_err++; $display("FAIL wrap_data0 got=%h exp=00B0", bus.data_out); end
    bus.in_valid = 4'b0000;
    tick();
  endtask

  // rr_ptr is 1 here; req0 still wins because it is the only requester.
  task automatic test_reset_mid();
    bus.in_valid = 4'b0001;
    bus.in_last = 4'b0000;
    set_data(0, 16'hC000);
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0001) begin n_err++; $display("FAIL rm_rdy0 got=%b exp=0001", bus.in_ready); end
    tick();
    n_cmp++;
    if (bus.data_out !== 16'hC000 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rm_beat got=%h/%b exp=C000/1", bus.data_out, bus.out_valid); end
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b0101;
    set_data(2, 16'h2002);
    tick();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0000) begin n_err++; $display("FAIL rm_rdy_in_reset got=%b exp=0000", bus.in_ready); end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.data_out !== 16'h0000 || bus.out_last !== 1'b0) begin n_err++; $display("FAIL rm_cleared got=%b/%h/%b exp=0/0000/0", bus.out_valid, bus.data_out, bus.out_last); end
    reset = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_last = 4'b0101;
    set_data(0, 16'hC001);
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0001) begin n_err++; $display("FAIL rm_idle_ptr0 got=%b exp=0001", bus.in_ready); end
    tick();
    n_cmp++;
    if (bus.data_out !== 16'hC001) begin n_err++; $display("FAIL rm_data0 got=%h exp=C001", bus.data_out); end
`ifdef RV_ARB_ID_EN
    n_cmp++;
    if (bus.out_id !== 2'd0) begin n_err++; $display("FAIL rm_id0 got=%0d exp=0", bus.out_id); end
`endif
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0100) begin n_err++; $display("FAIL rm_req2_rdy got=%b exp=0100", bus.in_ready); end
    tick();
    n_cmp++;
    if (bus.data_out !== 16'h2002 || bus.out_last !== 1'b1) begin n_err++; $display("FAIL rm_req2_data got=%h/%b exp=2002/1", bus.data_out, bus.out_last); end
`ifdef RV_ARB_ID_EN
    n_cmp++;
    if (bus.out_id !== 2'd2) begin n_err++; $display("FAIL rm_id2 got=%0d exp=2", bus.out_id); end
`endif
    bus.in_valid = 4'b0000;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rm_drain got=%b exp=0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_packet();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
